alu_control_muldiv: RTL and testbench

- Next-generation EX-stage ALU control with a WIDTH-parametrised iterative multiply/divide sequencer and HI/LO registers.
- Decodes ALUOp/Funct into the 4-bit ALU operation code.
- Runs MULT/MULTU/DIV/DIVU over multiple cycles, stalling the pipeline while it works.
- Owns HI/LO for MFHI/MFLO/MTHI/MTLO. Sits between the main control decoder and the ALU/writeback mux.

---
 rtl/alu_control_muldiv.sv | 177 +++++++++++++++++
 tb/tb_alu_control_muldiv.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_muldiv.sv
// EX-stage ALU control: ALUOp/Funct decode plus an iterative MULT/DIV sequencer
// that owns HI/LO and stalls the pipeline for WIDTH+1 cycles per operation.
module alu_control_muldiv #(
  parameter int unsigned WIDTH         = 32,
  parameter bit          ENABLE_MULDIV = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       out_alu_op,
  output logic [1:0]       hilo_sel,
  output logic             stall_o,
  output logic             busy_o,
  output logic             illegal_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    counter;
  logic [W2-1:0]    mcand, acc;
  logic [WIDTH-1:0] opb;          // multiplier (shifted right) or divisor
  logic [WIDTH-1:0] quot, rem, dividend_raw;
  logic             neg_q, neg_r, div_zero;

  logic is_r, is_muldiv_f, is_mfhi, is_mflo, is_mthi, is_mtlo, start, sgn;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_r        = (alu_op == 2'b10);
  assign is_muldiv_f = ENABLE_MULDIV && (funct[5:2] == 4'b0110);
  assign is_mfhi     = ENABLE_MULDIV && (funct == 6'b010000);
  assign is_mflo     = ENABLE_MULDIV && (funct == 6'b010010);
  assign is_mthi     = ENABLE_MULDIV && (funct == 6'b010001);
  assign is_mtlo     = ENABLE_MULDIV && (funct == 6'b010011);

  assign start   = valid_i && is_r && is_muldiv_f && (state == S_IDLE);
  assign stall_o = start || (state == S_MUL) || (state == S_DIV);
  assign busy_o  = (state != S_IDLE);

  // ALU operation decode; unknown combinations fall to 0000 with illegal flagged
  always_comb begin
    out_alu_op = 4'b0000;
    illegal_o  = 1'b0;
    case (alu_op)
      2'b00: out_alu_op = 4'b0100;
      2'b01: out_alu_op = 4'b1100;
      2'b10: begin
        case (funct)
          6'b100000: out_alu_op = 4'b0100;
          6'b100010: out_alu_op = 4'b1100;
          6'b100100: out_alu_op = 4'b0000;
          6'b100101: out_alu_op = 4'b0010;
          6'b101010: out_alu_op = 4'b1110;
          6'b100110: out_alu_op = 4'b0110;
          6'b001000: out_alu_op = 4'b0001;
          default: begin
            if (is_muldiv_f || is_mfhi || is_mflo || is_mthi || is_mtlo)
              out_alu_op = 4'b0100;
            else
              illegal_o = 1'b1;
          end
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

  always_comb begin
    hilo_sel = 2'b00;
    if (valid_i && is_r && is_mfhi)      hilo_sel = 2'b01;
    else if (valid_i && is_r && is_mflo) hilo_sel = 2'b10;
  end

  // Signed variants (funct[0]==0) work on magnitudes; the sign is reapplied at the end
  assign sgn   = ~funct[0];
  assign a_mag = (sgn && rs_val[WIDTH-1]) ? (~rs_val + WIDTH'(1)) : rs_val;
  assign b_mag = (sgn && rt_val[WIDTH-1]) ? (~rt_val + WIDTH'(1)) : rt_val;

  // One shift-add step; the last step's sum feeds the result directly
  logic [W2-1:0] acc_nxt, mul_res;
  assign acc_nxt = acc + (opb[0] ? mcand : W2'(0));
  assign mul_res = neg_q ? (~acc_nxt + W2'(1)) : acc_nxt;

  // One restoring-division step: remainder < divisor, so W+1 bits suffice for the trial
  logic [WIDTH:0]   div_tmp, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nxt, quot_nxt, q_res, r_res;
  assign div_tmp  = {rem, quot[WIDTH-1]};
  assign div_diff = div_tmp - {1'b0, opb};
  assign div_ge   = ~div_diff[WIDTH];
  assign rem_nxt  = div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0];
  assign quot_nxt = {quot[WIDTH-2:0], div_ge};
  assign q_res    = neg_q ? (~quot_nxt + WIDTH'(1)) : quot_nxt;
  assign r_res    = neg_r ? (~rem_nxt + WIDTH'(1)) : rem_nxt;

  logic last;
  assign last = (counter == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      counter      <= '0;
      mcand        <= '0;
      acc          <= '0;
      opb          <= '0;
      quot         <= '0;
      rem          <= '0;
      dividend_raw <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_zero     <= 1'b0;
      hi_o         <= '0;
      lo_o         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !flush_i) begin
            mcand        <= W2'(a_mag);
            acc          <= '0;
            opb          <= b_mag;
            quot         <= a_mag;
            rem          <= '0;
            dividend_raw <= rs_val;
            neg_q        <= sgn && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            neg_r        <= sgn && rs_val[WIDTH-1];
            div_zero     <= (rt_val == '0);
            counter      <= '0;
            state        <= funct[1] ? S_DIV : S_MUL;
          end
          if (valid_i && is_r && is_mthi) hi_o <= rs_val;
          if (valid_i && is_r && is_mtlo) lo_o <= rs_val;
        end
        S_MUL: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else begin
            acc     <= acc_nxt;
            mcand   <= mcand << 1;
            opb     <= opb >> 1;
            counter <= counter + CW'(1);
            if (last) begin
              hi_o  <= mul_res[W2-1:WIDTH];
              lo_o  <= mul_res[WIDTH-1:0];
              state <= S_DONE;
            end
          end
        end
        S_DIV: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else begin
            rem     <= rem_nxt;
            quot    <= quot_nxt;
            counter <= counter + CW'(1);
            if (last) begin
              hi_o  <= div_zero ? dividend_raw : r_res;
              lo_o  <= div_zero ? '1 : q_res;
              state <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Directed bench for alu_control_muldiv: expected HI/LO results are queued at issue
// and checked by a monitor when the DUT reaches its one-cycle DONE state.
`timescale 1ns/1ps
module tb_alu_control_muldiv;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_i = 1'b0;
  logic         flush_i = 1'b0;
  logic [1:0]   alu_op = 2'b00;
  logic [5:0]   funct = 6'b000000;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic [3:0]   out_alu_op;
  logic [1:0]   hilo_sel;
  logic         stall_o, busy_o, illegal_o;
  logic [W-1:0] hi_o, lo_o;

  alu_control_muldiv #(.WIDTH(W), .ENABLE_MULDIV(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .flush_i(flush_i),
    .alu_op(alu_op), .funct(funct), .rs_val(rs_val), .rt_val(rt_val),
    .out_alu_op(out_alu_op), .hilo_sel(hilo_sel), .stall_o(stall_o),
    .busy_o(busy_o), .illegal_o(illegal_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } exp_t;

  exp_t         exp_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI = 6'b010001, F_MTLO  = 6'b010011;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: the DONE cycle (busy, not stalled) presents a finished result
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && busy_o && !stall_o) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: hi=0x%0h lo=0x%0h with empty queue", hi_o, lo_o);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_hi"}, hi_o, e.hi);
          check({e.name, "_lo"}, lo_o, e.lo);
        end
      end
    end
  end

  // Issue a mult/div, hold it while stalled, and count stall cycles; returns in DONE
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input string name);
    int   n = 0;
    exp_t e;
    e.hi = ehi; e.lo = elo; e.name = name;
    exp_q.push_back(e);
    model_hi = ehi;
    model_lo = elo;
    @(negedge clk);
    alu_op = 2'b10; funct = f; rs_val = a; rt_val = b; valid_i = 1'b1;
    #1;
    while (stall_o && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({name, "_stall_cycles"}, W'(n), W'(W + 1));
  endtask

  task automatic retire();
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  logic [12:0] dec_tab [0:16] = '{
    {2'b00, 6'b000000, 4'b0100, 1'b0}, {2'b01, 6'b000000, 4'b1100, 1'b0},
    {2'b10, 6'b100000, 4'b0100, 1'b0}, {2'b10, 6'b100010, 4'b1100, 1'b0},
    {2'b10, 6'b100100, 4'b0000, 1'b0}, {2'b10, 6'b100101, 4'b0010, 1'b0},
    {2'b10, 6'b101010, 4'b1110, 1'b0}, {2'b10, 6'b100110, 4'b0110, 1'b0},
    {2'b10, 6'b001000, 4'b0001, 1'b0}, {2'b10, 6'b010000, 4'b0100, 1'b0},
    {2'b10, 6'b010010, 4'b0100, 1'b0}, {2'b10, 6'b010001, 4'b0100, 1'b0},
    {2'b10, 6'b010011, 4'b0100, 1'b0}, {2'b10, 6'b011000, 4'b0100, 1'b0},
    {2'b10, 6'b011011, 4'b0100, 1'b0}, {2'b10, 6'b111111, 4'b0000, 1'b1},
    {2'b11, 6'b100000, 4'b0000, 1'b1}
  };

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [12:0] v;

    // Reset state
    #12;
    check("rst_busy",  W'(busy_o),  W'(0));
    check("rst_stall", W'(stall_o), W'(0));
    check("rst_hi", hi_o, '0);
    check("rst_lo", lo_o, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode sweep (valid low so nothing executes)
    for (int i = 0; i < 17; i++) begin
      v = dec_tab[i];
      @(negedge clk);
      alu_op = v[12:11]; funct = v[10:5];
      #1;
      check($sformatf("dec%0d_code", i), W'(out_alu_op), W'(v[4:1]));
      check($sformatf("dec%0d_illegal", i), W'(illegal_o), W'(v[0]));
    end

    // MTHI then MFHI, MTLO then MFLO: no stall, value visible next cycle
    @(negedge clk);
    alu_op = 2'b10; funct = F_MTHI; rs_val = 32'h0000_1234; valid_i = 1'b1;
    #1 check("mthi_stall", W'(stall_o), W'(0));
    @(negedge clk);
    funct = F_MFHI; rs_val = '0;
    #1;
    check("mfhi_sel", W'(hilo_sel), W'(2'b01));
    check("mfhi_val", hi_o, 32'h0000_1234);
    @(negedge clk);
    funct = F_MTLO; rs_val = 32'h0000_5678;
    @(negedge clk);
    funct = F_MFLO;
    #1;
    check("mflo_sel", W'(hilo_sel), W'(2'b10));
    check("mflo_val", lo_o, 32'h0000_5678);
    model_hi = 32'h0000_1234;
    model_lo = 32'h0000_5678;
    retire();

    // MULT followed directly by MFLO
    run_op(F_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5");
    @(negedge clk);
    funct = F_MFLO;
    #1;
    check("mult_mflo_sel", W'(hilo_sel), W'(2'b10));
    check("mult_mflo_val", lo_o, 32'hFFFF_FFF1);
    check("mult_mflo_stall", W'(stall_o), W'(0));
    retire();

    run_op(F_MULTU, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, "multu"); retire();
    run_op(F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, "mult_minmin"); retire();
    run_op(F_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2"); retire();
    run_op(F_DIVU,  32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, "divu_by0"); retire();
    run_op(F_DIV,   32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_by0"); retire();
    run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf"); retire();
    run_op(F_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, "divu_100d7"); retire();

    // Flush a DIV mid-computation: HI/LO keep their prior values
    @(negedge clk);
    alu_op = 2'b10; funct = F_DIV; rs_val = 32'd1000; rt_val = 32'd3; valid_i = 1'b1;
    repeat (10) @(negedge clk);
    flush_i = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush_busy",  W'(busy_o),  W'(0));
    check("flush_stall", W'(stall_o), W'(0));
    check("flush_hi", hi_o, model_hi);
    check("flush_lo", lo_o, model_lo);

    // Asynchronous reset in the middle of a MULT
    @(negedge clk);
    alu_op = 2'b10; funct = F_MULT; rs_val = 32'd7; rt_val = 32'd9; valid_i = 1'b1;
    repeat (5) @(negedge clk);
    valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy",  W'(busy_o),  W'(0));
    check("midrst_stall", W'(stall_o), W'(0));
    check("midrst_hi", hi_o, '0);
    check("midrst_lo", lo_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(F_MULT, 32'd7, 32'd9, 32'h0, 32'd63, "mult_after_rst"); retire();

    repeat (3) @(negedge clk);
    check("queue_empty", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
